vga_char_fetch: RTL and testbench

VGA_CHAR_FETCH -- requirements
Module: vga_char_fetch

---
 rtl/vga_char_fetch.sv | 208 ++++++++++++++++++++
 tb/tb_vga_char_fetch.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_char_fetch.sv
// Double-buffered character-row fetcher: prefetches the next text row from SDRAM while the current row is displayed.
// Optional sticky late-fetch detection is compiled in with VGA_FETCH_UNDERRUN_EN.
module vga_char_fetch (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [9:0]  raster_x,
  input  logic [9:0]  raster_y,
  input  logic [8:0]  mode_config,
  input  logic [23:0] base_addr_in,
  input  logic [23:0] disp_addr_in,
  output logic [7:0]  disp_data_out,
  output logic        mem_req_out,
  output logic [23:0] mem_addr_out,
  input  logic        mem_ack_in,
  input  logic        mem_valid_in,
  input  logic [7:0]  mem_data_in,
  output logic        underrun_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_t;

  fetch_state_t state_r, state_next_s;

  logic [7:0]  buf0_r [0:79];
  logic [7:0]  buf1_r [0:79];

  logic [6:0]  cols_s;
  logic [4:0]  rows_m1_s;
  logic [3:0]  char_y_s;
  logic [5:0]  row_s;
  logic        row_start_s;
  logic        frame_trig_s;
  logic        trig_s;
  logic [5:0]  target_s;
  logic [23:0] fetch_base_s;

  logic [6:0]  idx_r;
  logic [6:0]  idx_inc_s;
  logic [6:0]  fetch_cols_r;
  logic [23:0] fetch_start_r;
  logic        fetch_go_s;
  logic        byte_wr_s;
  logic        fetch_done_s;

  logic        disp_sel_r;
  logic        fill_valid_r;
  logic        disp_valid_r;
  logic [23:0] disp_base_r;
  logic [6:0]  disp_cols_r;
  logic [5:0]  disp_row_r;

  logic [23:0] disp_off_s;
  logic        in_range_s;
  logic [6:0]  rd_idx_s;
  logic [7:0]  rd_byte_s;
  logic        unused_s;

  assign cols_s    = mode_config[0] ? 7'd40 : 7'd80;
  assign rows_m1_s = mode_config[1] ? 5'd14 : 5'd29;
  assign char_y_s  = mode_config[1] ? raster_y[4:1] : raster_y[3:0];
  assign row_s     = mode_config[1] ? {1'b0, raster_y[9:5]} : raster_y[9:4];

  assign row_start_s  = (raster_x == 10'd0) && (char_y_s == 4'd0) && (raster_y < 10'd480);
  assign frame_trig_s = (raster_x == 10'd0) && (raster_y == 10'd480);
  // The last row has nothing below it; row 0 is prefetched during vertical blanking instead.
  assign trig_s       = (row_start_s && (row_s < {1'b0, rows_m1_s})) || frame_trig_s;
  assign target_s     = frame_trig_s ? 6'd0 : (row_s + 6'd1);
  assign fetch_base_s = base_addr_in + (24'(target_s) * 24'(cols_s));
  assign idx_inc_s    = idx_r + 7'd1;

  assign disp_off_s = disp_addr_in - disp_base_r;
  assign in_range_s = disp_off_s < 24'(disp_cols_r);
  assign rd_idx_s   = in_range_s ? disp_off_s[6:0] : 7'd0;
  assign rd_byte_s  = disp_sel_r ? buf1_r[rd_idx_s] : buf0_r[rd_idx_s];

  assign unused_s = ^{mode_config[8:2], disp_row_r};

  // Fetch state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Fetch next-state logic: one read outstanding at a time.
  always_comb begin
    state_next_s = state_r;
    fetch_go_s   = 1'b0;
    byte_wr_s    = 1'b0;
    fetch_done_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (trig_s) begin
          state_next_s = ST_REQ;
          fetch_go_s   = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (mem_ack_in) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (mem_valid_in) begin
          byte_wr_s = 1'b1;
          if (idx_inc_s < fetch_cols_r) begin
            state_next_s = ST_REQ;
          end else begin
            state_next_s = ST_IDLE;
            fetch_done_s = 1'b1;
          end
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Fetch datapath; cols and base are frozen for the whole fetch.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      idx_r         <= 7'd0;
      fetch_cols_r  <= 7'd80;
      fetch_start_r <= 24'd0;
      mem_addr_out  <= 24'd0;
      mem_req_out   <= 1'b0;
    end else begin
      if (fetch_go_s) begin
        idx_r         <= 7'd0;
        fetch_cols_r  <= cols_s;
        fetch_start_r <= fetch_base_s;
        mem_addr_out  <= fetch_base_s;
      end else if (byte_wr_s) begin
        idx_r        <= idx_inc_s;
        mem_addr_out <= fetch_start_r + 24'(idx_inc_s);
      end
      mem_req_out <= (state_next_s == ST_REQ);
    end
  end

  // Line buffer storage (not reset); the fill side is the one not being displayed.
  always_ff @(posedge clk_in) begin
    if (byte_wr_s) begin
      if (disp_sel_r) begin
        buf0_r[idx_r] <= mem_data_in;
      end else begin
        buf1_r[idx_r] <= mem_data_in;
      end
    end
  end

  // Buffer swap and valid-bit hand-over at each row start.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      disp_sel_r   <= 1'b0;
      fill_valid_r <= 1'b0;
      disp_valid_r <= 1'b0;
      disp_base_r  <= 24'd0;
      disp_cols_r  <= 7'd80;
      disp_row_r   <= 6'd0;
    end else if (row_start_s) begin
      disp_sel_r   <= ~disp_sel_r;
      disp_row_r   <= row_s;
      disp_base_r  <= 24'(row_s) * 24'(cols_s);
      disp_cols_r  <= cols_s;
      disp_valid_r <= fill_valid_r;
      fill_valid_r <= 1'b0;
    end else if (fetch_done_s) begin
      fill_valid_r <= 1'b1;
    end
  end

  // Display read port: a space character whenever the cell is missing or off-row.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      disp_data_out <= 8'h20;
    end else begin
      disp_data_out <= (disp_valid_r && in_range_s) ? rd_byte_s : 8'h20;
    end
  end

`ifdef VGA_FETCH_UNDERRUN_EN
  // Sticky flag: a new row or trigger arrived before the previous fetch finished.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      underrun_out <= 1'b0;
    end else if ((trig_s || row_start_s) && (state_r != ST_IDLE)) begin
      underrun_out <= 1'b1;
    end
  end
`else
  assign underrun_out = 1'b0;
`endif

endmodule

// File: tb/tb_vga_char_fetch.sv
// Directed bench for vga_char_fetch; SDRAM model returns a byte derived from the requested address.
module tb_vga_char_fetch;

  logic        clk_in = 1'b0;
  logic        rst_n;
  logic [9:0]  raster_x;
  logic [9:0]  raster_y;
  logic [8:0]  mode_config;
  logic [23:0] base_addr_in;
  logic [23:0] disp_addr_in;
  logic [7:0]  disp_data_out;
  logic        mem_req_out;
  logic [23:0] mem_addr_out;
  logic        mem_ack_in;
  logic        mem_valid_in;
  logic [7:0]  mem_data_in;
  logic        underrun_out;

  int errors = 0;
  int checks = 0;
  logic [23:0] addr_q[$];
  logic        exp_underrun;

  vga_char_fetch dut (
    .clk_in(clk_in), .rst_n(rst_n), .raster_x(raster_x), .raster_y(raster_y),
    .mode_config(mode_config), .base_addr_in(base_addr_in),
    .disp_addr_in(disp_addr_in), .disp_data_out(disp_data_out),
    .mem_req_out(mem_req_out), .mem_addr_out(mem_addr_out),
    .mem_ack_in(mem_ack_in), .mem_valid_in(mem_valid_in),
    .mem_data_in(mem_data_in), .underrun_out(underrun_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] pat(input logic [23:0] a);
    return a[7:0] + a[15:8] + 8'h31;
  endfunction

  assign mem_data_in = pat(mem_addr_out);

  always @(posedge clk_in) begin
    if (mem_req_out && mem_ack_in) addr_q.push_back(mem_addr_out);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_row(input logic [9:0] y);
    raster_y = y;
    raster_x = 10'd0;
    tick(1);
    raster_x = 10'd1;
  endtask

  task automatic check_fetch(input string tag, input int n, input logic [23:0] first);
    int bad;
    bad = 0;
    check({tag, "_count"}, addr_q.size(), n);
    for (int i = 0; i < addr_q.size(); i++) begin
      if (addr_q[i] !== first + 24'(i)) bad++;
    end
    check({tag, "_seq"}, bad, 0);
    check({tag, "_last"}, (addr_q.size() > 0) ? addr_q[addr_q.size() - 1] : 24'hFFFFFF,
          first + 24'(n - 1));
  endtask

  initial begin
    rst_n        = 1'b0;
    raster_x     = 10'd1;
    raster_y     = 10'd480;
    mode_config  = 9'd0;
    base_addr_in = 24'h001000;
    disp_addr_in = 24'd0;
    mem_ack_in   = 1'b1;
    mem_valid_in = 1'b1;
`ifdef VGA_FETCH_UNDERRUN_EN
    exp_underrun = 1'b1;
`else
    exp_underrun = 1'b0;
`endif
    tick(3);
    check("rst_disp", disp_data_out, 8'h20);
    check("rst_req", mem_req_out, 1'b0);
    check("rst_addr", mem_addr_out, 24'd0);
    check("rst_underrun", underrun_out, 1'b0);

    // 80-col frame prefetch of row 0
    rst_n = 1'b1;
    tick(2);
    addr_q.delete();
    pulse_row(10'd480);
    tick(200);
    check_fetch("row0_80", 80, 24'h001000);
    check("row0_idle", mem_req_out, 1'b0);

    // Row 0 displayed; row 1 prefetched
    addr_q.delete();
    disp_addr_in = 24'd5;
    raster_y = 10'd0;
    raster_x = 10'd0;
    tick(1);
    check("pre_swap", disp_data_out, 8'h20);
    raster_x = 10'd1;
    tick(1);
    check("cell5", disp_data_out, pat(24'h001005));
    tick(200);
    check_fetch("row1_80", 80, 24'h001050);

    // Row 1 displayed: offset bounds
    disp_addr_in = 24'd200;
    pulse_row(10'd16);
    tick(1);
    check("addr200", disp_data_out, 8'h20);
    disp_addr_in = 24'd85;
    tick(1);
    check("addr85", disp_data_out, pat(24'h001055));
    disp_addr_in = 24'd79;
    tick(1);
    check("addr79", disp_data_out, 8'h20);
    disp_addr_in = 24'd159;
    tick(1);
    check("addr159", disp_data_out, pat(24'h00109F));
    tick(200);

    // Last row must not trigger; frame end targets row 0
    addr_q.delete();
    pulse_row(10'd464);
    tick(10);
    check("row29_req", mem_req_out, 1'b0);
    check("row29_reads", addr_q.size(), 0);
    pulse_row(10'd480);
    tick(3);
    check("frame_target", (addr_q.size() > 0) ? addr_q[0] : 24'hFFFFFF, 24'h001000);
    tick(200);

    // 40x15 mode, base 0
    mode_config  = 9'd3;
    base_addr_in = 24'd0;
    pulse_row(10'd480);
    tick(100);
    addr_q.delete();
    pulse_row(10'd0);
    tick(100);
    check_fetch("row1_40", 40, 24'd40);
    disp_addr_in = 24'd45;
    pulse_row(10'd32);
    tick(1);
    check("cell45", disp_data_out, pat(24'd45));
    tick(100);

    // Stalled SDRAM: no ack
    mode_config  = 9'd0;
    base_addr_in = 24'h001000;
    mem_ack_in   = 1'b0;
    mem_valid_in = 1'b0;
    pulse_row(10'd0);
    tick(3);
    check("stall_req", mem_req_out, 1'b1);
    check("stall_addr", mem_addr_out, 24'h001050);
    tick(2000);
    disp_addr_in = 24'd85;
    pulse_row(10'd16);
    tick(1);
    check("underrun", underrun_out, exp_underrun);
    check("stall_disp", disp_data_out, 8'h20);
    check("stall_req2", mem_req_out, 1'b1);
    check("stall_addr2", mem_addr_out, 24'h001050);

    // Reset during WAIT, then late valid
    mem_ack_in = 1'b1;
    tick(1);
    mem_ack_in = 1'b0;
    check("wait_req", mem_req_out, 1'b0);
    rst_n = 1'b0;
    tick(1);
    rst_n        = 1'b1;
    mem_valid_in = 1'b1;
    mem_ack_in   = 1'b1;
    tick(5);
    check("post_rst_req", mem_req_out, 1'b0);
    check("post_rst_addr", mem_addr_out, 24'd0);
    check("post_rst_disp", disp_data_out, 8'h20);
    check("post_rst_underrun", underrun_out, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
